// File: rtl/timer_pkg.sv
// Shared encodings for the generalised timer channel: register map, TCR/TCSR/TIER
// field layout, clock-select, clear-select and compare-output action codes.
package timer_pkg;

  localparam logic [2:0] ADDR_TCNT  = 3'd0;
  localparam logic [2:0] ADDR_TCORA = 3'd1;
  localparam logic [2:0] ADDR_TCORB = 3'd2;
  localparam logic [2:0] ADDR_TCR   = 3'd3;
  localparam logic [2:0] ADDR_TCSR  = 3'd4;
  localparam logic [2:0] ADDR_TPSC  = 3'd5;
  localparam logic [2:0] ADDR_TIER  = 3'd6;

  localparam int TCR_CKS_LO  = 0;
  localparam int TCR_CCLR_LO = 3;
  localparam int TCR_ONESHOT = 5;

  localparam int TCSR_CMFA   = 0;
  localparam int TCSR_CMFB   = 1;
  localparam int TCSR_OVF    = 2;
  localparam int TCSR_OSA_LO = 3;
  localparam int TCSR_OSB_LO = 5;
  localparam int TCSR_ADTE   = 7;

  localparam int TIER_CMIEA = 0;
  localparam int TIER_CMIEB = 1;
  localparam int TIER_OVIE  = 2;

  typedef enum logic [2:0] {
    CKS_STOP    = 3'd0,
    CKS_INT     = 3'd1,
    CKS_RISE    = 3'd2,
    CKS_FALL    = 3'd3,
    CKS_BOTH    = 3'd4,
    CKS_CASCADE = 3'd5,
    CKS_STOP6   = 3'd6,
    CKS_STOP7   = 3'd7
  } cks_e;

  typedef enum logic [1:0] {
    CCLR_NONE    = 2'd0,
    CCLR_MATCH_A = 2'd1,
    CCLR_MATCH_B = 2'd2,
    CCLR_TMRI    = 2'd3
  } cclr_e;

  typedef enum logic [1:0] {
    OS_NONE   = 2'd0,
    OS_LOW    = 2'd1,
    OS_HIGH   = 2'd2,
    OS_TOGGLE = 2'd3
  } os_e;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_e;

  // Next level of the compare output pin for a given action code.
  function automatic logic os_apply(input os_e act, input logic cur);
    case (act)
      OS_LOW:    return 1'b0;
      OS_HIGH:   return 1'b1;
      OS_TOGGLE: return ~cur;
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/timer_edge_sync.sv
// Two-flop synchroniser with an edge register; emits a one-clk pulse on the
// selected edge of an asynchronous input.
module timer_edge_sync
  import timer_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  async_in,
  input  edge_e edge_sel,
  output logic  pulse
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [2:0] fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      fill  <= 3'b000;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
      fill  <= {fill[1:0], 1'b1};
    end
  end

  // Edges are ignored until sync2 and prev both hold post-reset samples, so an
  // input already high at reset release does not look like a rising edge.
  always_comb begin
    pulse = 1'b0;
    if (fill[2]) begin
      case (edge_sel)
        EDGE_RISE: pulse = sync2 & ~prev;
        EDGE_FALL: pulse = ~sync2 & prev;
        default:   pulse = sync2 ^ prev;
      endcase
    end
  end

endmodule

// File: rtl/timer_channel_gen.sv
// Parametrised single-channel up-counter timer with prescaler, external clock,
// one-shot mode and W1C flags. Define TIMER_CASCADE_EN for cascade_in/ovf_tick.
module timer_channel_gen
  import timer_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int PRESCALE_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tmci,
  input  logic                 tmri,
  input  logic                 reg_wr,
  input  logic [2:0]           reg_addr,
  input  logic [BIT_WIDTH-1:0] reg_wdata,
  output logic [BIT_WIDTH-1:0] reg_rdata,
  output logic                 tmo,
  output logic                 cmia,
  output logic                 cmib,
  output logic                 ovi,
  output logic                 adc_req
`ifdef TIMER_CASCADE_EN
  ,
  input  logic                 cascade_in,
  output logic                 ovf_tick
`endif
);

  localparam int PSC_W = (1 << PRESCALE_W) - 1;

  logic [BIT_WIDTH-1:0]  tcnt;
  logic [BIT_WIDTH-1:0]  tcora;
  logic [BIT_WIDTH-1:0]  tcorb;
  cks_e                  cks;
  cclr_e                 cclr;
  logic                  oneshot;
  logic                  cmfa;
  logic                  cmfb;
  logic                  ovf;
  os_e                   osa;
  os_e                   osb;
  logic                  adte;
  logic                  cmiea;
  logic                  cmieb;
  logic                  ovie;
  logic [PRESCALE_W-1:0] tpsc;
  logic [PSC_W-1:0]      psc_cnt;
  logic                  match_a_q;
  logic                  match_b_q;

  logic wr_tcnt, wr_tcora, wr_tcorb, wr_tcr, wr_tcsr, wr_tpsc, wr_tier;
  logic [PSC_W-1:0] psc_mask;
  logic psc_tick;
  logic tmci_pulse;
  logic tmri_pulse;
  edge_e tmci_sel;
  logic count_en;
  logic match_a, match_b;
  logic set_a, set_b;
  logic clr_cond;
  logic inc_en;
  logic ovf_set;
  logic tmo_next;

  assign wr_tcnt  = reg_wr && (reg_addr == ADDR_TCNT);
  assign wr_tcora = reg_wr && (reg_addr == ADDR_TCORA);
  assign wr_tcorb = reg_wr && (reg_addr == ADDR_TCORB);
  assign wr_tcr   = reg_wr && (reg_addr == ADDR_TCR);
  assign wr_tcsr  = reg_wr && (reg_addr == ADDR_TCSR);
  assign wr_tpsc  = reg_wr && (reg_addr == ADDR_TPSC);
  assign wr_tier  = reg_wr && (reg_addr == ADDR_TIER);

  // Tick whenever the low TPSC bits of the free-running counter are all ones.
  assign psc_mask = ~({PSC_W{1'b1}} << tpsc);
  assign psc_tick = ((psc_cnt & psc_mask) == psc_mask);

  always_comb begin
    case (cks)
      CKS_FALL: tmci_sel = EDGE_FALL;
      CKS_BOTH: tmci_sel = EDGE_BOTH;
      default:  tmci_sel = EDGE_RISE;
    endcase
  end

  timer_edge_sync u_tmci_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (tmci),
    .edge_sel (tmci_sel),
    .pulse    (tmci_pulse)
  );

  timer_edge_sync u_tmri_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (tmri),
    .edge_sel (EDGE_RISE),
    .pulse    (tmri_pulse)
  );

  always_comb begin
    case (cks)
      CKS_INT:  count_en = psc_tick;
      CKS_RISE,
      CKS_FALL,
      CKS_BOTH: count_en = tmci_pulse;
`ifdef TIMER_CASCADE_EN
      CKS_CASCADE: count_en = cascade_in;
`endif
      default:  count_en = 1'b0;
    endcase
  end

  assign match_a = (tcnt == tcora);
  assign match_b = (tcnt == tcorb);
  assign set_a   = match_a & ~match_a_q;
  assign set_b   = match_b & ~match_b_q;

  always_comb begin
    case (cclr)
      CCLR_MATCH_A: clr_cond = match_a;
      CCLR_MATCH_B: clr_cond = match_b;
      CCLR_TMRI:    clr_cond = tmri_pulse;
      default:      clr_cond = 1'b0;
    endcase
  end

  // In one-shot mode the counter must not step past TCORA during the match cycle.
  assign inc_en  = count_en & ~(oneshot & match_a);
  assign ovf_set = ~wr_tcnt & ~clr_cond & inc_en & (&tcnt);

  // When A and B hit together the B action owns the pin.
  always_comb begin
    tmo_next = tmo;
    if (set_b)      tmo_next = os_apply(osb, tmo);
    else if (set_a) tmo_next = os_apply(osa, tmo);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt      <= '0;
      tcora     <= '1;
      tcorb     <= '1;
      cks       <= CKS_STOP;
      cclr      <= CCLR_NONE;
      oneshot   <= 1'b0;
      cmfa      <= 1'b0;
      cmfb      <= 1'b0;
      ovf       <= 1'b0;
      osa       <= OS_NONE;
      osb       <= OS_NONE;
      adte      <= 1'b0;
      cmiea     <= 1'b0;
      cmieb     <= 1'b0;
      ovie      <= 1'b0;
      tpsc      <= '0;
      psc_cnt   <= '0;
      match_a_q <= 1'b0;
      match_b_q <= 1'b0;
      tmo       <= 1'b0;
      adc_req   <= 1'b0;
`ifdef TIMER_CASCADE_EN
      ovf_tick  <= 1'b0;
`endif
    end else begin
      match_a_q <= match_a;
      match_b_q <= match_b;

      if (wr_tcnt)       tcnt <= reg_wdata;
      else if (clr_cond) tcnt <= '0;
      else if (inc_en)   tcnt <= tcnt + 1'b1;

      if (wr_tcora) tcora <= reg_wdata;
      if (wr_tcorb) tcorb <= reg_wdata;

      if (wr_tcr) begin
        cks     <= cks_e'(reg_wdata[TCR_CKS_LO +: 3]);
        cclr    <= cclr_e'(reg_wdata[TCR_CCLR_LO +: 2]);
        oneshot <= reg_wdata[TCR_ONESHOT];
      end else if (oneshot && set_a) begin
        cks <= CKS_STOP;
      end

      if (wr_tpsc) tpsc <= reg_wdata[PRESCALE_W-1:0];
      if (wr_tpsc || wr_tcr) psc_cnt <= '0;
      else                   psc_cnt <= psc_cnt + 1'b1;

      if (wr_tier) begin
        cmiea <= reg_wdata[TIER_CMIEA];
        cmieb <= reg_wdata[TIER_CMIEB];
        ovie  <= reg_wdata[TIER_OVIE];
      end

      // A hardware set in the same clk as a write-1-clear keeps the flag.
      cmfa <= set_a   | (cmfa & ~(wr_tcsr & reg_wdata[TCSR_CMFA]));
      cmfb <= set_b   | (cmfb & ~(wr_tcsr & reg_wdata[TCSR_CMFB]));
      ovf  <= ovf_set | (ovf  & ~(wr_tcsr & reg_wdata[TCSR_OVF]));

      if (wr_tcsr) begin
        osa  <= os_e'(reg_wdata[TCSR_OSA_LO +: 2]);
        osb  <= os_e'(reg_wdata[TCSR_OSB_LO +: 2]);
        adte <= reg_wdata[TCSR_ADTE];
      end

      tmo     <= tmo_next;
      adc_req <= set_a & adte;
`ifdef TIMER_CASCADE_EN
      ovf_tick <= ovf_set;
`endif
    end
  end

  assign cmia = cmfa & cmiea;
  assign cmib = cmfb & cmieb;
  assign ovi  = ovf & ovie;

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_TCNT:  reg_rdata = tcnt;
      ADDR_TCORA: reg_rdata = tcora;
      ADDR_TCORB: reg_rdata = tcorb;
      ADDR_TCR:   reg_rdata[5:0] = {oneshot, cclr, cks};
      ADDR_TCSR:  reg_rdata[7:0] = {adte, osb, osa, ovf, cmfb, cmfa};
      ADDR_TPSC:  reg_rdata[PRESCALE_W-1:0] = tpsc;
      ADDR_TIER:  reg_rdata[2:0] = {ovie, cmieb, cmiea};
      default:    reg_rdata = '0;
    endcase
  end

endmodule

// File: doc/timer_channel_gen.md
# timer_channel_gen

Parametrised single-channel up-counter timer: the next-generation channel for the timer units. It generalises the 8-bit channel to BIT_WIDTH bits and adds a programmable power-of-two prescaler, selectable external-clock edge, one-shot mode, interrupt enables and write-1-to-clear status flags. It sits behind a simple register write/read port and drives compare-match output, interrupt lines and an ADC start request.

## Interface
- BIT_WIDTH, 8, counter/compare/register data width (8..32)
- PRESCALE_W, 3, width of prescaler exponent field; internal tick = clk/2^TPSC
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- tmci  in  1  external count clock (asynchronous)
- tmri  in  1  external counter clear (asynchronous)
- reg_wr  in  1  register write strobe, one clk
- reg_addr  in  3  register select: 0 TCNT, 1 TCORA, 2 TCORB, 3 TCR, 4 TCSR, 5 TPSC, 6 TIER
- reg_wdata  in  BIT_WIDTH  write data
- reg_rdata  out  BIT_WIDTH  combinational read of reg_addr; unused bits read 0
- tmo  out  1  compare-match output pin
- cmia, cmib, ovi  out  1  level interrupts = flag AND enable
- adc_req  out  1  one-clk ADC start pulse

## Operation
- TCR: [2:0] CKS (0 stop, 1 internal prescaled, 2 tmci rise, 3 tmci fall, 4 tmci both, 5 cascade, 6–7 stop); [4:3] CCLR (0 none, 1 on match A, 2 on match B, 3 on tmri rising); [5] ONESHOT.
- TCSR: [0] CMFA, [1] CMFB, [2] OVF (write 1 clears, write 0 no effect); [4:3] OSA, [6:5] OSB (tmo action: 0 none, 1 drive 0, 2 drive 1, 3 toggle); [7] ADTE.
- TIER: [0] CMIEA, [1] CMIEB, [2] OVIE. TPSC: [PRESCALE_W-1:0] exponent.
- Count tick: internal prescaler is a free-running counter reset by rst_n and by any TPSC/TCR write; tick when low TPSC bits all-ones (TPSC=0 → every clk).
- Match A/B: TCNT == TCORA/TCORB, evaluated every clk regardless of tick; flag set on the rising edge of the match condition.
- Clear: CCLR=1/2 → TCNT loads 0 on the clk after the match cycle (TCNT holds the compare value exactly one clk). CCLR=3 → 0 on the clk after the synchronised tmri rising edge.
- Overflow: tick with TCNT all-ones → TCNT wraps to 0, OVF set.
- Simultaneous A and B match: OSB action applies to tmo; both flags set.
- Precedence on TCNT: register write > clear > increment.
- Flag set and write-1-clear in same clk: set wins.
- ONESHOT=1: first match A clears TCR.CKS to 0; counter halts at TCORA (or 0 if CCLR=1).
- adc_req: pulse coincident with CMFA set when ADTE=1.

## Timing
- Reset values: TCNT 0, TCORA/TCORB all-ones, TCR/TCSR/TPSC/TIER 0, tmo 0, all interrupts 0, adc_req 0, reg_rdata per reg_addr.
- tmci/tmri: 2-flop synchroniser + edge register; edge to TCNT change = 3 clk; minimum pulse width 2 clk.
- Write to TCNT/TCORx visible on reg_rdata the next clk; match uses updated value that clk.
- Flags and tmo update 1 clk after TCNT reaches compare value; interrupts same clk as flag.
- rst_n assertion mid-count: all state cleared immediately; synchroniser history cleared so no spurious edge on release.

## Configuration
- TIMER_CASCADE_EN defined: adds input cascade_in (1 clk pulse from upstream channel) and output ovf_tick (1 clk pulse on every overflow); CKS=5 counts cascade_in pulses.
- Undefined: neither port exists; CKS=5 behaves as stop.

## Structure
- Package timer_pkg: register address constants, CKS/CCLR/output-action encodings, TCSR/TIER bit indices.
- Sub-module timer_edge_sync: 2-flop synchroniser plus rise/fall/both edge pulse, instantiated for tmci and tmri.

## Test plan
- CKS=1, TPSC=0, TCORA=5, CCLR=1, OSA=3 → TCNT 0..5 repeating period 6 clk, tmo toggles each period, CMFA set.
- CKS=1, TPSC=2 → TCNT increments every 4 clk; at 0xFF wraps to 0, OVF=1, ovi=1 only with OVIE=1.
- CKS=2, tmci period 20 clk → one increment per rising edge, 3 clk after edge; CKS=4 → two per period.
- TCORA=TCORB=3, OSA=2, OSB=1 → on match tmo=0 (B precedence), both flags set; write TCSR=0x01 clears only CMFA.
- ONESHOT=1, TCORA=10, ADTE=1 → single adc_req pulse, TCR.CKS reads 0, TCNT stays 10.
- CCLR=3, pulse tmri at TCNT=0x40 → TCNT=0 on 3rd clk after edge; rst_n low mid-count → all outputs at reset values immediately.
